axis_frame_collect: RTL and testbench

AXIS_FRAME_COLLECT -- requirements
Module: axis_frame_collect

---
 rtl/axis_frame_collect.sv | 151 +++++++++++++++
 tb/tb_axis_frame_collect.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_collect.sv
// axis_frame_collect: packs WORD_WIDTH-bit core words into one DATA_WIDTH-bit
// frame for an AXIS packager. Word 0 lands in the LSBs. A frame closes on the
// last word slot or on in_last; unwritten slots read as zero.
// Optional build macro FRAME_TIMEOUT_EN adds an idle counter that flushes a
// partial frame after TIMEOUT_CYCLES cycles with no accepted word.
// Ports:
//   m_axis_c2h_aclk  clock (rising edge)
//   rstn             synchronous active-low reset
//   in_valid/in_data/in_last/in_ready   core word input handshake
//   data_valid/data/data_next           frame output handshake
//   fill_level       words held in the accumulator
//   frame_cnt        frames consumed, wraps at 16 bits
module axis_frame_collect #(
    parameter int unsigned DATA_WIDTH     = 16000,
    parameter int unsigned WORD_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  m_axis_c2h_aclk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  data_next,
    output logic [7:0]            fill_level,
    output logic [15:0]           frame_cnt
);

    localparam int unsigned WORDS    = (DATA_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned ACC_W    = WORDS * WORD_WIDTH;
    localparam logic [7:0]  LAST_IDX = 8'(WORDS - 1);

    typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_d;
    logic [ACC_W-1:0]  acc, acc_d, acc_wr;
    logic [DATA_WIDTH-1:0] data_d;
    logic              data_valid_d, in_ready_d;
    logic [7:0]        fill_d;
    logic [15:0]       frame_cnt_d;
    logic              accept, consume, slot_free, complete, timeout;

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt, idle_d;

    // Idle counter runs only while a partial frame is waiting in FILL.
    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (state == FILL && fill_level != 8'd0 && !accept) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_d = idle_cnt + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!rstn) idle_cnt <= '0;
        else       idle_cnt <= idle_d;
    end
`else
    always_comb timeout = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign consume   = data_valid && data_next;
    assign slot_free = !data_valid || data_next;

    // Next-state and datapath decode.
    always_comb begin
        state_d      = state;
        acc_d        = acc;
        acc_wr       = acc;
        fill_d       = fill_level;
        data_d       = data;
        data_valid_d = data_valid && !data_next;
        frame_cnt_d  = frame_cnt + 16'(consume);
        complete     = 1'b0;

        // Place the incoming word at slot fill_level.
        if (accept) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                if (fill_level == 8'(k)) acc_wr[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
            end
        end

        case (state)
            FILL: begin
                if (accept) begin
                    acc_d  = acc_wr;
                    fill_d = fill_level + 8'd1;
                end
                complete = (accept && (in_last || fill_level == LAST_IDX)) || timeout;
                if (complete) begin
                    if (slot_free) begin
                        // Accumulator is cleared so the next frame's empty slots read zero.
                        data_d       = acc_wr[DATA_WIDTH-1:0];
                        data_valid_d = 1'b1;
                        acc_d        = '0;
                        fill_d       = 8'd0;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (data_next) begin
                    data_d       = acc[DATA_WIDTH-1:0];
                    data_valid_d = 1'b1;
                    acc_d        = '0;
                    fill_d       = 8'd0;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // Ready returns one cycle after leaving HOLD, and immediately after reset.
        in_ready_d = (state == FILL) && (state_d == FILL);
    end

    // Control and accumulator registers.
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!rstn) begin
            state      <= FILL;
            acc        <= '0;
            fill_level <= 8'd0;
            data_valid <= 1'b0;
            in_ready   <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            fill_level <= fill_d;
            data_valid <= data_valid_d;
            in_ready   <= in_ready_d;
            frame_cnt  <= frame_cnt_d;
        end
    end

    // Output frame register; contents are don't-care out of reset.
    always_ff @(posedge m_axis_c2h_aclk) begin
        data <= data_d;
    end

endmodule

// File: tb/tb_axis_frame_collect.sv
module tb_axis_frame_collect;

    localparam int unsigned DW = 16000;
    localparam int unsigned WW = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [WW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          data_valid;
    logic [DW-1:0] data;
    logic          data_next;
    logic [7:0]    fill_level;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_vec, exp1, exp2;

    always #5 clk = ~clk;

    axis_frame_collect dut (
        .m_axis_c2h_aclk (clk),
        .rstn            (rstn),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .data_valid      (data_valid),
        .data            (data),
        .data_next       (data_next),
        .fill_level      (fill_level),
        .frame_cnt       (frame_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int idx;
        checks++;
        assert (obs === exp) else begin
            errors++;
            idx = 0;
            for (int i = DW/WW - 1; i >= 0; i--)
                if (obs[i*WW +: WW] !== exp[i*WW +: WW]) idx = i;
            $error("FAIL %s word %0d observed %0h expected %0h", tag, idx,
                   obs[idx*WW +: WW], exp[idx*WW +: WW]);
        end
    endtask

    initial begin
        bit dv_seen;
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; data_next = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rstn = 1'b1;
        tick();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Short frame closed by in_last.
        data_next = 1'b1;
        send(64'hA, 1'b0); send(64'hB, 1'b0); send(64'hC, 1'b1);
        exp_vec = '0;
        exp_vec[191:0] = {64'hC, 64'hB, 64'hA};
        chk("short_valid", 64'(data_valid), 64'd1);
        chk_vec("short_data", data, exp_vec);
        chk("short_fill", 64'(fill_level), 64'd0);
        tick();
        chk("short_consumed_valid", 64'(data_valid), 64'd0);
        chk("short_cnt", 64'(frame_cnt), 64'd1);

        // Full frame, in_data = k.
        for (int k = 0; k < 250; k++) begin
            exp_vec[k*WW +: WW] = 64'(k);
            send(64'(k), 1'b0);
        end
        chk("full_valid", 64'(data_valid), 64'd1);
        chk_vec("full_data", data, exp_vec);
        chk("full_top_word", 64'(data[15999:15936]), 64'd249);
        tick();
        chk("full_cnt", 64'(frame_cnt), 64'd2);

        // Two frames with the packager stalled: second frame waits in HOLD.
        data_next = 1'b0;
        for (int k = 0; k < 250; k++) begin
            exp1[k*WW +: WW] = 64'(1000 + k);
            exp2[k*WW +: WW] = 64'(2000 + k);
        end
        for (int k = 0; k < 250; k++) send(64'(1000 + k), 1'b0);
        chk("f1_valid", 64'(data_valid), 64'd1);
        chk("f1_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 250; k++) send(64'(2000 + k), 1'b0);
        chk("hold_ready", 64'(in_ready), 64'd0);
        chk("hold_fill", 64'(fill_level), 64'd250);
        tick(); tick(); tick();
        chk("hold_ready_later", 64'(in_ready), 64'd0);
        chk("hold_valid", 64'(data_valid), 64'd1);
        chk_vec("hold_data_stable", data, exp1);
        data_next = 1'b1;
        tick();
        data_next = 1'b0;
        chk_vec("release_data", data, exp2);
        chk("release_valid", 64'(data_valid), 64'd1);
        chk("release_cnt", 64'(frame_cnt), 64'd3);
        chk("release_ready_same", 64'(in_ready), 64'd0);
        chk("release_fill", 64'(fill_level), 64'd0);
        tick();
        chk("release_ready_next", 64'(in_ready), 64'd1);

        // Back-to-back single-word frames: valid never drops.
        data_next = 1'b1;
        send(64'h11, 1'b1);
        chk("b2b1_valid", 64'(data_valid), 64'd1);
        chk("b2b1_data", data[63:0], 64'h11);
        chk("b2b1_cnt", 64'(frame_cnt), 64'd4);
        send(64'h22, 1'b1);
        chk("b2b2_valid", 64'(data_valid), 64'd1);
        chk("b2b2_data", data[63:0], 64'h22);
        chk("b2b2_upper", data[127:64], 64'd0);
        send(64'h33, 1'b1);
        chk("b2b3_valid", 64'(data_valid), 64'd1);
        chk("b2b3_data", data[63:0], 64'h33);
        chk("b2b3_cnt", 64'(frame_cnt), 64'd6);
        tick();
        chk("b2b_end_valid", 64'(data_valid), 64'd0);
        chk("b2b_end_cnt", 64'(frame_cnt), 64'd7);

        // Partial frame with no timeout logic waits indefinitely.
        for (int k = 0; k < 5; k++) send(64'(256 + k), 1'b0);
        dv_seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (data_valid) dv_seen = 1'b1;
        end
        chk("no_timeout_delivery", 64'(dv_seen), 64'd0);
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("last_without_valid_fill", 64'(fill_level), 64'd5);
        chk("last_without_valid_dv", 64'(data_valid), 64'd0);

        // Reset mid-frame.
        for (int k = 5; k < 100; k++) send(64'(256 + k), 1'b0);
        chk("mid_fill", 64'(fill_level), 64'd100);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_fill", 64'(fill_level), 64'd0);
        chk("midrst_valid", 64'(data_valid), 64'd0);
        chk("midrst_cnt", 64'(frame_cnt), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        tick();
        chk("midrst_ready_back", 64'(in_ready), 64'd1);
        send(64'h55, 1'b1);
        exp_vec = '0;
        exp_vec[63:0] = 64'h55;
        chk_vec("after_rst_frame", data, exp_vec);
        tick();
        chk("after_rst_cnt", 64'(frame_cnt), 64'd1);

        // Reset while a frame sits in HOLD.
        data_next = 1'b0;
        send(64'h66, 1'b1);
        send(64'h77, 1'b1);
        chk("hold2_ready", 64'(in_ready), 64'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("holdrst_valid", 64'(data_valid), 64'd0);
        chk("holdrst_fill", 64'(fill_level), 64'd0);
        chk("holdrst_cnt", 64'(frame_cnt), 64'd0);
        tick();
        data_next = 1'b1;
        send(64'h88, 1'b1);
        exp_vec = '0;
        exp_vec[63:0] = 64'h88;
        chk_vec("after_holdrst_frame", data, exp_vec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
